switch_pulse_conditioner: RTL and testbench

// Front-end conditioner between raw board switches/keys and the FIFO's read/write strobes.
// Per channel: 2-flop synchroniser, debounce filter, rising-edge one-shot.

---
 rtl/switch_pulse_conditioner.sv | 115 +++++++++++
 tb/tb_switch_pulse_conditioner.sv | 127 ++++++++++++
 2 files changed

// File: rtl/switch_pulse_conditioner.sv
// Per-channel switch front end: 2-flop synchroniser, debounce filter and press one-shot.
// Define DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat pulses; the default build has none.
module switch_pulse_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // An illegal parameter set leaves the strobes permanently quiet rather than misbehaving.
    localparam logic PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic          sync1_reg, sync2_reg;
            logic          level_reg, level_next;
            logic          pulse_reg, pulse_next;
            logic [CW-1:0] cnt_reg, cnt_next;
            logic          accept;
            logic          rise;

            always_comb begin
                accept     = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);
                rise       = accept && sync2_reg;
                level_next = accept ? sync2_reg : level_reg;
                cnt_next   = '0;
                if ((sync2_reg != level_reg) && !accept) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

`ifdef DEBOUNCE_AUTOREPEAT_EN
            localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

            logic [RW-1:0] rcnt_reg, rcnt_next;
            logic          rphase_reg, rphase_next;
            logic          rep_fire;

            // rphase_reg=0 waits out the initial delay, 1 runs the steady repeat period.
            // Gating on level_next suppresses a repeat on the very edge the release is accepted.
            always_comb begin
                rep_fire    = 1'b0;
                rcnt_next   = rcnt_reg;
                rphase_next = rphase_reg;
                if (!level_reg || !level_next) begin
                    rcnt_next   = '0;
                    rphase_next = 1'b0;
                end else if (!rphase_reg) begin
                    if (rcnt_reg == DELAY_LAST) begin
                        rep_fire    = 1'b1;
                        rcnt_next   = '0;
                        rphase_next = 1'b1;
                    end else begin
                        rcnt_next = rcnt_reg + 1'b1;
                    end
                end else begin
                    if (rcnt_reg == PERIOD_LAST) begin
                        rep_fire  = 1'b1;
                        rcnt_next = '0;
                    end else begin
                        rcnt_next = rcnt_reg + 1'b1;
                    end
                end
                pulse_next = (rise || rep_fire) && PARAMS_OK;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rcnt_reg   <= '0;
                    rphase_reg <= 1'b0;
                end else begin
                    rcnt_reg   <= rcnt_next;
                    rphase_reg <= rphase_next;
                end
            end
`else
            always_comb begin
                pulse_next = rise && PARAMS_OK;
            end
`endif

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    pulse_reg <= 1'b0;
                end else begin
                    sync1_reg <= in[gi];
                    sync2_reg <= sync1_reg;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    pulse_reg <= pulse_next;
                end
            end

            assign level[gi] = level_reg;
            assign pulse[gi] = pulse_reg;
        end
    endgenerate

endmodule

// File: tb/tb_switch_pulse_conditioner.sv
// Directed bench for switch_pulse_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
// Expectations follow the auto-repeat build when DEBOUNCE_AUTOREPEAT_EN is defined.
module tb_switch_pulse_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] in_r = 2'b00;
    logic [1:0] level;
    logic [1:0] pulse;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_pulse_conditioner #(
        .CHANNELS       (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in_r),
        .level(level),
        .pulse(pulse)
    );

    task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse expected on edge e of a press accepted at edge t0 whose release is accepted at edge fall.
    function automatic bit exp_pulse(input int e, input int t0, input int fall);
        int d;
        if (e == t0 && t0 < fall) return 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (e > t0 && e < fall) begin
            d = e - t0;
            if (d == 8) return 1'b1;
            if (d > 8 && ((d - 8) % 4) == 0) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    // Drive mask for edges 1..hold, then 0; level expected on [t0, fall).
    task automatic run_case(input string tag, input logic [1:0] mask, input int hold,
                            input int total, input int t0, input int fall);
        logic [1:0] exp_l, exp_p;
        for (int e = 1; e <= total; e++) begin
            in_r = (e <= hold) ? mask : 2'b00;
            tick();
            exp_l = (e >= t0 && e < fall) ? mask : 2'b00;
            exp_p = exp_pulse(e, t0, fall) ? mask : 2'b00;
            check_val({tag, "_level"}, level, exp_l);
            check_val({tag, "_pulse"}, pulse, exp_p);
        end
    endtask

    initial begin
        // Reset held with both keys down: nothing may appear.
        in_r = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_hold_level", level, 2'b00);
            check_val("rst_hold_pulse", pulse, 2'b00);
        end
        reset = 1'b1;
        run_case("rst_release", 2'b11, 8, 20, 6, 14);

        // Single press on channel 0, long hold, release.
        run_case("press0", 2'b01, 20, 30, 6, 26);

        // Three-cycle glitch on channel 1 is one sample short of acceptance.
        run_case("glitch1", 2'b10, 3, 12, 1000, 1000);

        // Simultaneous press on both channels.
        run_case("both", 2'b11, 8, 20, 6, 14);

        // Reset pulsed mid-count with the key still held.
        in_r = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mid_pre_level", level, 2'b00);
            check_val("mid_pre_pulse", pulse, 2'b00);
        end
        reset = 1'b0;
        #1;
        check_val("mid_async_level", level, 2'b00);
        check_val("mid_async_pulse", pulse, 2'b00);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("mid_rst_level", level, 2'b00);
            check_val("mid_rst_pulse", pulse, 2'b00);
        end
        reset = 1'b1;
        run_case("mid_release", 2'b01, 7, 16, 6, 13);

        // Long hold: repeat train, with the would-be repeat on the release edge suppressed.
        run_case("repeat0", 2'b01, 28, 40, 6, 34);

        // Async reset while a level is asserted clears it immediately.
        run_case("pre_async", 2'b10, 10, 7, 6, 1000);
        reset = 1'b0;
        #1;
        check_val("async_clr_level", level, 2'b00);
        check_val("async_clr_pulse", pulse, 2'b00);
        in_r = 2'b00;
        tick();
        reset = 1'b1;
        run_case("idle", 2'b00, 0, 8, 1000, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
